core_ctrl: RTL and testbench

Multi-cycle control sequencer for the nano RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back. It drives the instruction- and data-memory request handshakes and the IR, PC and register-file write enables, using the per-instruction control flags produced by the combinational decoder. It also provides a bus watchdog, a halt-on-fault state and a retired-instruction counter.

---
 rtl/core_pkg.sv | 36 +++
 rtl/bus_watchdog.sv | 44 ++++
 rtl/core_ctrl.sv | 176 +++++++++++++++++
 tb/tb_core_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared state/cause encodings and helpers for the core_ctrl sequencer.
package core_pkg;

  // Width of the retired-instruction counter.
  localparam int unsigned INSTR_COUNT_W = 32;

  // Sequencer states; encodings are visible on state_o for debug.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Reason the core stopped in HALT.
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } cause_e;

  // True when the instruction needs the data-memory stage.
  function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
    return mem_read | mem_write;
  endfunction

  // A load that is also a store cannot be sequenced; treat it like an illegal opcode.
  function automatic logic is_bad_decode(input logic illegal, input logic mem_read,
                                         input logic mem_write);
    return illegal | (mem_read & mem_write);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts consecutive un-acked wait cycles and flags expiry at the limit.
// A limit of 0 disables the watchdog entirely.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_expired
);

  localparam int unsigned      CNT_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic             WD_ENABLE = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  // Next count: clear wins, otherwise advance on each waiting cycle, saturating at the limit.
  always_comb begin
    w_count_nxt = r_count;
    if (i_clear) begin
      w_count_nxt = '0;
    end else if (i_wait && (r_count != LIMIT)) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Wait-cycle counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // Expiry only while still waiting, so a same-cycle ack always wins.
  assign o_expired = WD_ENABLE & i_wait & (r_count == LIMIT);

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the nano RV32I core,
// with a shared bus watchdog, halt-on-fault and a retired-instruction counter.
module core_ctrl
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     imem_req_o,
  input  logic                     imem_ack_i,
  output logic                     dmem_req_o,
  output logic                     dmem_we_o,
  input  logic                     dmem_ack_i,
  input  logic                     dec_reg_write_i,
  input  logic                     dec_mem_read_i,
  input  logic                     dec_mem_write_i,
  input  logic                     dec_illegal_i,
  output logic                     ir_write_o,
  output logic                     pc_write_o,
  output logic                     reg_write_o,
  output logic                     halted_o,
  output logic [1:0]               cause_o,
  output logic [2:0]               state_o,
  output logic [INSTR_COUNT_W-1:0] instr_count_o
);

  state_e                   r_state;
  state_e                   w_state_nxt;
  cause_e                   r_cause;
  cause_e                   w_cause_nxt;
  logic [INSTR_COUNT_W-1:0] r_instr_count;
  logic [INSTR_COUNT_W-1:0] w_instr_count_nxt;

  logic w_imem_req;
  logic w_dmem_req;
  logic w_dmem_we;
  logic w_ir_write;
  logic w_pc_write;
  logic w_reg_write;
  logic w_halted;

  logic w_wd_wait;
  logic w_wd_clear;
  logic w_wd_expired;

  // The watchdog sees a wait cycle whenever a bus request is open and unanswered.
  assign w_wd_wait  = ((r_state == ST_FETCH) && !imem_ack_i) ||
                      ((r_state == ST_MEM)   && !dmem_ack_i);
  // Any state change restarts the wait count for the next bus phase.
  assign w_wd_clear = (w_state_nxt != r_state);

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clear  (w_wd_clear),
    .i_wait   (w_wd_wait),
    .o_expired(w_wd_expired)
  );

  // Next-state, halt cause and strobe decode from the current state plus same-cycle acks.
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_imem_req  = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ack_i) begin
          w_ir_write  = 1'b1;
          w_state_nxt = ST_DECODE;
        end else if (w_wd_expired) begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = CAUSE_IMEM_TO;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_bad_decode(dec_illegal_i, dec_mem_read_i, dec_mem_write_i)) begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = CAUSE_ILLEGAL;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_mem_op(dec_mem_read_i, dec_mem_write_i)) begin
          w_state_nxt = ST_MEM;
        end else if (dec_reg_write_i) begin
          w_state_nxt = ST_WB;
        end else begin
          // Branch/jump with no destination retires straight from EXEC.
          w_pc_write  = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_MEM: begin
        // Request and direction stay constant until the ack; IR keeps the flags stable.
        w_dmem_req = 1'b1;
        w_dmem_we  = dec_mem_write_i;
        if (dmem_ack_i) begin
          if (dec_mem_write_i) begin
            w_pc_write  = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_WB;
          end
        end else if (w_wd_expired) begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = CAUSE_DMEM_TO;
        end else begin
          w_state_nxt = ST_MEM;
        end
      end
      ST_WB: begin
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        // Sticky until reset; all strobes stay low.
        w_halted    = 1'b1;
        w_state_nxt = ST_HALT;
      end
      default: begin
        // Unused encodings are treated as a fault and parked in HALT.
        w_halted    = 1'b1;
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  // Retired-instruction count advances on every PC commit and wraps naturally.
  always_comb begin
    if (w_pc_write) begin
      w_instr_count_nxt = r_instr_count + INSTR_COUNT_W'(1);
    end else begin
      w_instr_count_nxt = r_instr_count;
    end
  end

  // State, cause and counter registers; written every cycle, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_FETCH;
      r_cause       <= CAUSE_NONE;
      r_instr_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cause       <= w_cause_nxt;
      r_instr_count <= w_instr_count_nxt;
    end
  end

  // Every output is held at zero while reset is asserted, dropping any open request.
  assign imem_req_o    = w_imem_req  & ~rst_i;
  assign dmem_req_o    = w_dmem_req  & ~rst_i;
  assign dmem_we_o     = w_dmem_we   & ~rst_i;
  assign ir_write_o    = w_ir_write  & ~rst_i;
  assign pc_write_o    = w_pc_write  & ~rst_i;
  assign reg_write_o   = w_reg_write & ~rst_i;
  assign halted_o      = w_halted    & ~rst_i;
  assign cause_o       = rst_i ? 2'd0 : r_cause;
  assign state_o       = rst_i ? 3'd0 : r_state;
  assign instr_count_o = rst_i ? {INSTR_COUNT_W{1'b0}} : r_instr_count;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed-vector bench for core_ctrl with hand-computed per-cycle expectations.
module tb_core_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic        imem_ack_i = 1'b0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ack_i = 1'b0;
  logic        dec_reg_write_i = 1'b0;
  logic        dec_mem_read_i = 1'b0;
  logic        dec_mem_write_i = 1'b0;
  logic        dec_illegal_i = 1'b0;
  logic        ir_write_o;
  logic        pc_write_o;
  logic        reg_write_o;
  logic        halted_o;
  logic [1:0]  cause_o;
  logic [2:0]  state_o;
  logic [31:0] instr_count_o;

  int n_checks = 0;
  int n_errors = 0;

  // State encodings as the bench expects them.
  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;
  // Strobe patterns: {imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write, halted}.
  localparam logic [6:0] SB_IDLE      = 7'b0000000;
  localparam logic [6:0] SB_FETCH     = 7'b1000000;
  localparam logic [6:0] SB_FETCH_ACK = 7'b1001000;
  localparam logic [6:0] SB_LOAD      = 7'b0100000;
  localparam logic [6:0] SB_STORE     = 7'b0110000;
  localparam logic [6:0] SB_STORE_ACK = 7'b0110100;
  localparam logic [6:0] SB_WB        = 7'b0000110;
  localparam logic [6:0] SB_BRANCH    = 7'b0000100;
  localparam logic [6:0] SB_HALT      = 7'b0000001;

  core_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .imem_req_o     (imem_req_o),
    .imem_ack_i     (imem_ack_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_ack_i     (dmem_ack_i),
    .dec_reg_write_i(dec_reg_write_i),
    .dec_mem_read_i (dec_mem_read_i),
    .dec_mem_write_i(dec_mem_write_i),
    .dec_illegal_i  (dec_illegal_i),
    .ir_write_o     (ir_write_o),
    .pc_write_o     (pc_write_o),
    .reg_write_o    (reg_write_o),
    .halted_o       (halted_o),
    .cause_o        (cause_o),
    .state_o        (state_o),
    .instr_count_o  (instr_count_o)
  );

  // 10 ns core clock.
  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {imem_req_o, dmem_req_o, dmem_we_o, ir_write_o, pc_write_o, reg_write_o, halted_o};
  endfunction

  task automatic set_dec(input logic rw, input logic rd, input logic wr, input logic ill);
    dec_reg_write_i = rw;
    dec_mem_read_i  = rd;
    dec_mem_write_i = wr;
    dec_illegal_i   = ill;
  endtask

  // One clock cycle: entered at a negedge, drives acks, checks state+strobes, advances to next negedge.
  task automatic tick(input string tag, input logic ia, input logic da,
                      input logic [2:0] st, input logic [6:0] sb);
    imem_ack_i = ia;
    dmem_ack_i = da;
    #1;
    chk_eq(tag, {22'd0, strobes(), st}, {22'd0, sb, st});
    @(negedge clk_i);
  endtask

  // Holds reset for one edge, checking that every output is zero meanwhile.
  task automatic do_reset(input string tag);
    rst_i      = 1'b1;
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    #1;
    chk_eq({tag, "/outs"}, {20'd0, strobes(), cause_o, state_o}, 32'd0);
    chk_eq({tag, "/count"}, instr_count_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    @(negedge clk_i);
    do_reset("rst0");
    chk_eq("rst0/state_after", {29'd0, state_o}, {29'd0, S_F});
    chk_eq("rst0/cause_after", {30'd0, cause_o}, 32'd0);

    // ALU (ADDI): 0,1,2,4 with both write strobes in cycle 4.
    set_dec(1'b1, 1'b0, 1'b0, 1'b0);
    tick("alu/c1", 1'b1, 1'b0, S_F, SB_FETCH_ACK);
    tick("alu/c2", 1'b0, 1'b0, S_D, SB_IDLE);
    tick("alu/c3", 1'b0, 1'b0, S_E, SB_IDLE);
    tick("alu/c4", 1'b0, 1'b0, S_W, SB_WB);
    chk_eq("alu/count", instr_count_o, 32'd1);

    // Load with 3 wait states: 4 MEM cycles, dmem_we low, then WB; 8 cycles total.
    set_dec(1'b1, 1'b1, 1'b0, 1'b0);
    tick("ld/c1", 1'b1, 1'b0, S_F, SB_FETCH_ACK);
    tick("ld/c2", 1'b0, 1'b0, S_D, SB_IDLE);
    tick("ld/c3", 1'b0, 1'b0, S_E, SB_IDLE);
    for (int i = 0; i < 3; i++) tick("ld/wait", 1'b0, 1'b0, S_M, SB_LOAD);
    tick("ld/ack", 1'b0, 1'b1, S_M, SB_LOAD);
    tick("ld/wb", 1'b0, 1'b0, S_W, SB_WB);
    chk_eq("ld/count", instr_count_o, 32'd2);
    chk_eq("ld/state_next", {29'd0, state_o}, {29'd0, S_F});

    // Store with one wait state: we=1, pc_write on the ack cycle, no reg_write.
    set_dec(1'b0, 1'b0, 1'b1, 1'b0);
    tick("st/c1", 1'b1, 1'b0, S_F, SB_FETCH_ACK);
    tick("st/c2", 1'b0, 1'b0, S_D, SB_IDLE);
    tick("st/c3", 1'b0, 1'b0, S_E, SB_IDLE);
    tick("st/wait", 1'b0, 1'b0, S_M, SB_STORE);
    tick("st/ack", 1'b0, 1'b1, S_M, SB_STORE_ACK);
    chk_eq("st/count", instr_count_o, 32'd3);

    // Branch with two fetch wait states: retires from EXEC.
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
    tick("br/fw1", 1'b0, 1'b0, S_F, SB_FETCH);
    tick("br/fw2", 1'b0, 1'b0, S_F, SB_FETCH);
    tick("br/c1", 1'b1, 1'b0, S_F, SB_FETCH_ACK);
    tick("br/c2", 1'b0, 1'b0, S_D, SB_IDLE);
    tick("br/c3", 1'b0, 1'b0, S_E, SB_BRANCH);
    chk_eq("br/count", instr_count_o, 32'd4);

    // Reset during MEM of a load: outputs zero during reset, FETCH with count 0 after.
    set_dec(1'b1, 1'b1, 1'b0, 1'b0);
    tick("rm/c1", 1'b1, 1'b0, S_F, SB_FETCH_ACK);
    tick("rm/c2", 1'b0, 1'b0, S_D, SB_IDLE);
    tick("rm/c3", 1'b0, 1'b0, S_E, SB_IDLE);
    tick("rm/mem", 1'b0, 1'b0, S_M, SB_LOAD);
    do_reset("rm/rst");
    tick("rm/after", 1'b0, 1'b0, S_F, SB_FETCH);
    chk_eq("rm/count_after", instr_count_o, 32'd0);

    // Counter wrap: preload all-ones during a non-retiring cycle, retire one branch.
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
    force dut.r_instr_count = 32'hFFFF_FFFF;
    tick("wrap/fw", 1'b0, 1'b0, S_F, SB_FETCH);
    release dut.r_instr_count;
    chk_eq("wrap/preload", instr_count_o, 32'hFFFF_FFFF);
    tick("wrap/c1", 1'b1, 1'b0, S_F, SB_FETCH_ACK);
    tick("wrap/c2", 1'b0, 1'b0, S_D, SB_IDLE);
    tick("wrap/c3", 1'b0, 1'b0, S_E, SB_BRANCH);
    chk_eq("wrap/count", instr_count_o, 32'd0);

    // Data-side timeout: 5 un-acked MEM cycles -> HALT cause 3.
    set_dec(1'b1, 1'b1, 1'b0, 1'b0);
    tick("dto/c1", 1'b1, 1'b0, S_F, SB_FETCH_ACK);
    tick("dto/c2", 1'b0, 1'b0, S_D, SB_IDLE);
    tick("dto/c3", 1'b0, 1'b0, S_E, SB_IDLE);
    for (int i = 0; i < 5; i++) tick("dto/wait", 1'b0, 1'b0, S_M, SB_LOAD);
    tick("dto/halt", 1'b0, 1'b1, S_H, SB_HALT);
    chk_eq("dto/cause", {30'd0, cause_o}, 32'd3);

    // Illegal opcode: HALT cause 1, no fetch request even with imem ack present.
    do_reset("ill/rst");
    set_dec(1'b0, 1'b0, 1'b0, 1'b1);
    tick("ill/c1", 1'b1, 1'b0, S_F, SB_FETCH_ACK);
    tick("ill/c2", 1'b0, 1'b0, S_D, SB_IDLE);
    chk_eq("ill/cause", {30'd0, cause_o}, 32'd1);
    for (int i = 0; i < 3; i++) tick("ill/halt", 1'b1, 1'b1, S_H, SB_HALT);
    chk_eq("ill/count", instr_count_o, 32'd0);

    // Load+store flags together are also fatal at DECODE.
    do_reset("ldst/rst");
    set_dec(1'b0, 1'b1, 1'b1, 1'b0);
    tick("ldst/c1", 1'b1, 1'b0, S_F, SB_FETCH_ACK);
    tick("ldst/c2", 1'b0, 1'b0, S_D, SB_IDLE);
    tick("ldst/halt", 1'b0, 1'b0, S_H, SB_HALT);
    chk_eq("ldst/cause", {30'd0, cause_o}, 32'd1);

    // Fetch timeout: 5 un-acked FETCH cycles -> HALT cause 2.
    do_reset("ito/rst");
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick("ito/wait", 1'b0, 1'b0, S_F, SB_FETCH);
    tick("ito/halt", 1'b1, 1'b0, S_H, SB_HALT);
    chk_eq("ito/cause", {30'd0, cause_o}, 32'd2);

    // Ack on the 5th fetch cycle beats the timeout and proceeds to DECODE.
    do_reset("iok/rst");
    for (int i = 0; i < 4; i++) tick("iok/wait", 1'b0, 1'b0, S_F, SB_FETCH);
    tick("iok/ack", 1'b1, 1'b0, S_F, SB_FETCH_ACK);
    tick("iok/dec", 1'b0, 1'b0, S_D, SB_IDLE);
    chk_eq("iok/cause", {30'd0, cause_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
